neuron_accumulator: RTL and testbench
=====================================

# neuron_accumulator

Sequential IEEE-754 single-precision accumulator sitting directly downstream of the combinational `multiply` stage in a neuron datapath. It consumes one weight×input product per handshake and sums a packet of products onto a per-packet bias. It optionally applies ReLU, then presents the neuron activation on a valid/ready output. It uses a multi-cycle align/add/normalise FSM, so no pipelined FP adder is needed.

## Interface
- `RELU_EN`, default 1, apply ReLU to the final sum (1) or pass it through raw (0).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  `in_data` holds a product.
- `in_ready`  out  1  block can accept a term.
- `in_data`  in  32  product (IEEE-754 single) from `multiply`.
- `in_last`  in  1  this term closes the packet.
- `bias`  in  32  packet bias; sampled on the first accepted term of each packet.
- `out_valid`  out  1  `out_data` holds a finished activation.
- `out_ready`  in  1  consumer takes `out_data`.
- `out_data`  out  32  activation (IEEE-754 single).

## Operation
- FSM states: IDLE, ALIGN, ADD, NORM, OUT. Reset state is IDLE.
- Outputs are combinational from the state:
  - `in_ready` = (state==IDLE).
  - `out_valid` = (state==OUT).
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_data`=0.
  - Accumulator=0, first-flag=1, last-flag=0, inf-flag=0.
- IDLE: on `in_valid&in_ready`, the block latches `in_data` as operand B and latches `in_last`.
  - Operand A = `bias` if first-flag=1, else the accumulator.
  - The block clears first-flag and goes to ALIGN.
- Operand decode:
  - exp==0 → zero; denormals are flushed.
  - exp==255 → infinity; this sets inf-flag with the sign of that operand.
  - Otherwise mantissa = {1, frac}, 24 bits.
- ALIGN: the block orders the operands by magnitude (exp, then mantissa), larger first.
  - It right-shifts the smaller mantissa by the exponent difference; shifted-out bits are discarded.
  - A difference of 24 or more → the smaller mantissa becomes 0.
- ADD: 25-bit add if the signs are equal, subtract (larger − smaller) otherwise.
  - Result sign = sign of the larger operand.
- NORM:
  - If bit24 is set → shift right 1, exp+1.
  - Otherwise left-shift by the leading-zero count (single-cycle priority encoder), exp−lz.
  - Zero mantissa → +0 (exact cancellation yields positive zero).
  - exp≤0 → +0.
  - exp≥255 → ±inf (`{sign,8'hFF,23'd0}`).
  - Rounding is truncation (toward zero).
  - If inf-flag=1 → the result is that infinity, and it stays sticky until the packet ends.
  - The block writes the result to the accumulator and goes to OUT if last-flag=1, else to IDLE.
- OUT: `out_data` = +0 if RELU_EN=1 and sign=1 (including −0); otherwise the accumulator.
  - On `out_ready`: first-flag←1, inf-flag←0, accumulator←0, then IDLE.
- `in_valid` is ignored outside IDLE, and `bias` is ignored except on a packet's first accept.
- A packet of one term is legal.

## Timing
- Accept at edge E0 → ALIGN during E0–E1, ADD during E1–E2, NORM during E2–E3.
- The accumulator is updated at E3.
- Throughput: at most one term per 4 cycles; `in_ready` is low for the 3 cycles after an accept.
- Latency: `out_valid` rises after E3 of the last term, 3 cycles after its accept.
- `out_valid` and `out_data` are held stable while `out_ready`=0; `in_ready`=0 throughout OUT.
- The cycle after the OUT handshake, `in_ready`=1 and a new packet may be accepted.
- `rst_n` low at any time (including mid-packet or in OUT) immediately forces the reset values; the partial sum is discarded.

## Test plan
- Single-term packet: `bias`=0x3F800000 (1.0), `in_data`=0x40000000 (2.0), `in_last`=1 → `out_data`=0x40400000 (3.0), `out_valid` 3 cycles after the accept.
- Four-term packet: `bias`=0, terms 1.0, 2.0, 3.0, 4.0 (last on 4.0) → 0x41200000 (10.0); `in_ready` pulses low 3 cycles after each accept.
- Cancellation and ReLU:
  - `bias`=0x40A00000 (5.0), term 0xC0A00000 (−5.0) → 0x00000000.
  - `bias`=0, term 0xC0000000 (−2.0): RELU_EN=1 → 0x00000000; RELU_EN=0 → 0xC0000000.
- Overflow and sticky infinity:
  - `bias`=0x7F7FFFFF plus term 0x7F7FFFFF → 0x7F800000.
  - A packet 0x7F800000 then 0xBF800000 (−1.0) → still 0x7F800000.
- Backpressure: hold `out_ready`=0 for 10 cycles with `in_valid`=1 → `out_valid`=1, `out_data` stable, `in_ready`=0, no term consumed. Raising `out_ready` completes the handshake, and the pending term is accepted on the next cycle.
- Reset mid-packet: accept 1.0 and 2.0 (not last), then pulse `rst_n` low → `out_valid`=0, `in_ready`=1. Then `bias`=0 with term 0x3F800000 as last → 0x3F800000.

Source files
------------

// File: rtl/neuron_accumulator_if.sv
// Handshake bundle between the multiply stage, the accumulator and the activation consumer.
// The accumulator takes the slave side; whoever drives terms and takes results uses master.
interface neuron_accumulator_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_data, in_last, bias, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, bias, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/neuron_accumulator.sv
// Multi-cycle FP32 accumulator: bias + sum of packet terms, optional ReLU, truncating rounding.
// One term per 4 cycles, result 3 cycles after the last accept; holds the result in OUT until taken.
module neuron_accumulator #(
  parameter bit RELU_EN = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  neuron_accumulator_if.slave  bus
);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp_t;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

  state_t      state, state_nxt;
  logic [31:0] acc, op_a, op_b;
  logic        first_flag, last_flag, inf_flag, inf_sign;
  logic        big_sign, sub;
  logic [7:0]  big_exp;
  logic [23:0] big_man, small_man;
  logic [24:0] sum;

  fp_t         a_f, b_f;
  logic [23:0] a_man, b_man, small_raw, small_shift;
  logic        a_inf, b_inf, a_ge_b;
  logic [7:0]  exp_diff;

  assign a_f    = op_a;
  assign b_f    = op_b;
  assign a_man  = (a_f.exp == 8'd0) ? 24'd0 : {1'b1, a_f.frac};
  assign b_man  = (b_f.exp == 8'd0) ? 24'd0 : {1'b1, b_f.frac};
  assign a_inf  = (a_f.exp == 8'hFF);
  assign b_inf  = (b_f.exp == 8'hFF);
  assign a_ge_b = ({a_f.exp, a_man} >= {b_f.exp, b_man});

  always_comb begin
    exp_diff    = a_ge_b ? (a_f.exp - b_f.exp) : (b_f.exp - a_f.exp);
    small_raw   = a_ge_b ? b_man : a_man;
    small_shift = (exp_diff >= 8'd24) ? 24'd0 : (small_raw >> exp_diff);
  end

  // Leading-zero count over the 24-bit sum, evaluated in one cycle.
  logic [4:0] lz;
  logic       lz_found;
  always_comb begin
    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!lz_found && sum[i]) begin
        lz       = 5'(23 - i);
        lz_found = 1'b1;
      end
    end
  end

  logic signed [9:0] norm_exp;
  logic [22:0]       norm_frac;
  logic [31:0]       norm_res;
  always_comb begin
    if (sum[24]) begin
      norm_frac = sum[23:1];
      norm_exp  = $signed({2'b00, big_exp}) + 10'sd1;
    end else begin
      norm_frac = 23'(sum[23:0] << lz);
      norm_exp  = $signed({2'b00, big_exp}) - $signed({5'd0, lz});
    end

    if (inf_flag)
      norm_res = {inf_sign, 8'hFF, 23'd0};
    else if (sum == 25'd0)
      norm_res = 32'd0;
    else if (norm_exp <= 10'sd0)
      norm_res = 32'd0;
    else if (norm_exp >= 10'sd255)
      norm_res = {big_sign, 8'hFF, 23'd0};
    else
      norm_res = {big_sign, norm_exp[7:0], norm_frac};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = last_flag ? OUT : IDLE;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= 32'd0;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      first_flag <= 1'b1;
      last_flag  <= 1'b0;
      inf_flag   <= 1'b0;
      inf_sign   <= 1'b0;
      big_sign   <= 1'b0;
      big_exp    <= 8'd0;
      big_man    <= 24'd0;
      small_man  <= 24'd0;
      sub        <= 1'b0;
      sum        <= 25'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.in_valid) begin
          op_b       <= bus.in_data;
          last_flag  <= bus.in_last;
          op_a       <= first_flag ? bus.bias : acc;
          first_flag <= 1'b0;
        end
        ALIGN: begin
          big_sign  <= a_ge_b ? a_f.sign : b_f.sign;
          big_exp   <= a_ge_b ? a_f.exp : b_f.exp;
          big_man   <= a_ge_b ? a_man : b_man;
          small_man <= small_shift;
          sub       <= a_f.sign ^ b_f.sign;
          // Once infinity is seen it wins for the rest of the packet.
          if (!inf_flag && a_inf) begin
            inf_flag <= 1'b1;
            inf_sign <= a_f.sign;
          end else if (!inf_flag && b_inf) begin
            inf_flag <= 1'b1;
            inf_sign <= b_f.sign;
          end
        end
        ADD: sum <= sub ? ({1'b0, big_man} - {1'b0, small_man})
                        : ({1'b0, big_man} + {1'b0, small_man});
        NORM: acc <= norm_res;
        OUT: if (bus.out_ready) begin
          first_flag <= 1'b1;
          inf_flag   <= 1'b0;
          acc        <= 32'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = (state != OUT)           ? 32'd0 :
                         (RELU_EN && acc[31])     ? 32'd0 : acc;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Drives a ReLU and a raw accumulator in lockstep; a scoreboard per instance checks every result.
module tb_neuron_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = 32'd0, bias = 32'd0;
  int          checks = 0, errors = 0;
  logic [31:0] q_r[$], q_p[$];
  int          w;

  always #5 clk = ~clk;

  neuron_accumulator_if ifc_r ();
  neuron_accumulator_if ifc_p ();

  assign ifc_r.in_valid = in_valid;  assign ifc_p.in_valid = in_valid;
  assign ifc_r.in_data = in_data;    assign ifc_p.in_data = in_data;
  assign ifc_r.in_last = in_last;    assign ifc_p.in_last = in_last;
  assign ifc_r.bias = bias;          assign ifc_p.bias = bias;
  assign ifc_r.out_ready = out_ready; assign ifc_p.out_ready = out_ready;

  neuron_accumulator #(.RELU_EN(1'b1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(ifc_r));
  neuron_accumulator #(.RELU_EN(1'b0)) dut_p (.clk(clk), .rst_n(rst_n), .bus(ifc_p));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] relu_exp, input logic [31:0] raw_exp);
    q_r.push_back(relu_exp);
    q_p.push_back(raw_exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc_r.out_valid && ifc_r.out_ready) begin
      if (q_r.size() == 0) begin
        checks++; errors++;
        $display("FAIL relu_unexpected_out: got %h expected nothing", ifc_r.out_data);
      end else check("relu_out", ifc_r.out_data, q_r.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && ifc_p.out_valid && ifc_p.out_ready) begin
      if (q_p.size() == 0) begin
        checks++; errors++;
        $display("FAIL raw_unexpected_out: got %h expected nothing", ifc_p.out_data);
      end else check("raw_out", ifc_p.out_data, q_p.pop_front());
    end
  end

  task automatic send(input logic [31:0] b, input logic [31:0] d, input logic l, output int waited);
    bias = b; in_data = d; in_last = l; in_valid = 1'b1;
    waited = 0;
    while (1) begin
      @(negedge clk);
      waited++;
      if (ifc_r.in_ready) break;
      if (waited > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_r.size() != 0 || q_p.size() != 0) && n < 100) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_in_ready", 32'(ifc_r.in_ready), 32'd1);
    check("reset_out_valid", 32'(ifc_r.out_valid), 32'd0);
    check("reset_out_data", ifc_r.out_data, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single term with latency and in_ready profile
    out_ready = 1'b0;
    push(32'h40400000, 32'h40400000);
    send(32'h3F800000, 32'h40000000, 1'b1, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_out_valid", 32'(ifc_r.out_valid), (i == 3) ? 32'd1 : 32'd0);
      check("t1_in_ready", 32'(ifc_r.in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Four-term packet, in_ready low after each accept
    push(32'h41200000, 32'h41200000);
    send(32'd0, 32'h3F800000, 1'b0, w); @(negedge clk); check("t2_busy1", 32'(ifc_r.in_ready), 32'd0);
    send(32'd0, 32'h40000000, 1'b0, w); @(negedge clk); check("t2_busy2", 32'(ifc_r.in_ready), 32'd0);
    send(32'd0, 32'h40400000, 1'b0, w); @(negedge clk); check("t2_busy3", 32'(ifc_r.in_ready), 32'd0);
    send(32'd0, 32'h40800000, 1'b1, w); @(negedge clk); check("t2_busy4", 32'(ifc_r.in_ready), 32'd0);

    // Cancellation and negative result
    push(32'h00000000, 32'h00000000);
    send(32'h40A00000, 32'hC0A00000, 1'b1, w);
    push(32'h00000000, 32'hC0000000);
    send(32'd0, 32'hC0000000, 1'b1, w);

    // Overflow and sticky infinity
    push(32'h7F800000, 32'h7F800000);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, w);
    push(32'h7F800000, 32'h7F800000);
    send(32'd0, 32'h7F800000, 1'b0, w);
    send(32'd0, 32'hBF800000, 1'b1, w);
    drain();

    // Backpressure with a pending term
    out_ready = 1'b0;
    push(32'h3F800000, 32'h3F800000);
    send(32'd0, 32'h3F800000, 1'b1, w);
    for (int i = 0; i < 20 && !ifc_r.out_valid; i++) @(negedge clk);
    bias = 32'd0; in_data = 32'h40000000; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_out_valid", 32'(ifc_r.out_valid), 32'd1);
      check("t5_out_data", ifc_r.out_data, 32'h3F800000);
      check("t5_in_ready", 32'(ifc_r.in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    push(32'h40000000, 32'h40000000);
    send(32'd0, 32'h40000000, 1'b1, w);
    check("t5_accept_next_cycle", 32'(w), 32'd2);
    drain();

    // Reset mid-packet
    send(32'd0, 32'h3F800000, 1'b0, w);
    send(32'd0, 32'h40000000, 1'b0, w);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("t6_out_valid", 32'(ifc_r.out_valid), 32'd0);
    check("t6_in_ready", 32'(ifc_r.in_ready), 32'd1);
    check("t6_raw_in_ready", 32'(ifc_p.in_ready), 32'd1);
    #2 rst_n = 1'b1;
    push(32'h3F800000, 32'h3F800000);
    send(32'd0, 32'h3F800000, 1'b1, w);
    drain();

    check("relu_queue_empty", 32'(q_r.size()), 32'd0);
    check("raw_queue_empty", 32'(q_p.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
